// File: rtl/dff_pulse_capture.sv
// Purpose: capture 'en'-strobed words into a 2-entry elastic buffer presented as a valid/ready stream.
// Latency: a strobe into an empty buffer appears on valid/q the next cycle; there is no bypass path.
// Backpressure: holds two words under stall; a strobe while full and not popping is dropped and sets sticky ovf.
// Optional: define DFF_CAPTURE_DROP_CNT_EN to add a saturating drop_cnt output, cleared by ovf_clr.
module dff_pulse_capture #(
  parameter int DATA_WIDTH = 16
`ifdef DFF_CAPTURE_DROP_CNT_EN
  ,
  parameter int CNT_WIDTH  = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  ready,
  input  logic                  ovf_clr,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  full,
  output logic                  ovf
`ifdef DFF_CAPTURE_DROP_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  drop_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop, drop;

`ifdef DFF_CAPTURE_DROP_CNT_EN
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
`endif

  // Handshake qualifiers derived from the registered occupancy.
  always_comb begin
    full  = (state_q == TWO);
    valid = (state_q != EMPTY);
    pop   = valid && ready;
    push  = en && (!full || pop);
    drop  = en && full && !pop;
  end

  // Occupancy FSM and entry movement; vacated entries are zeroed so q reads 0 when empty.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = d;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && !pop) begin
          tail_d  = d;
          state_d = TWO;
        end else if (pop && !push) begin
          head_d  = '0;
          state_d = EMPTY;
        end else if (pop && push) begin
          head_d  = d;
          state_d = ONE;
        end
      end
      TWO: begin
        if (pop && !push) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = ONE;
        end else if (pop && push) begin
          head_d  = tail_q;
          tail_d  = d;
          state_d = TWO;
        end
      end
      default: begin
        head_d  = '0;
        tail_d  = '0;
        state_d = EMPTY;
      end
    endcase
  end

  // Sticky overflow: a drop this cycle wins over a concurrent clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

`ifdef DFF_CAPTURE_DROP_CNT_EN
  // Saturating drop counter; a drop coinciding with a clear restarts the count at one.
  always_comb begin
    cnt_d = cnt_q;
    if (drop) begin
      if (ovf_clr) begin
        cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (ovf_clr) begin
      cnt_d = '0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign drop_cnt = cnt_q;
`endif

  // Buffer state registers; reset discards any buffered words.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q   = head_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_dff_pulse_capture.sv
// Bench for dff_pulse_capture: scoreboard queue of accepted words plus a small occupancy/ovf model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Optional drop counter checks follow DFF_CAPTURE_DROP_CNT_EN.
module tb_dff_pulse_capture;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk;
  logic          rstn;
  logic          en;
  logic [DW-1:0] d;
  logic          ready;
  logic          ovf_clr;
  logic          valid;
  logic [DW-1:0] q;
  logic          full;
  logic          ovf;
`ifdef DFF_CAPTURE_DROP_CNT_EN
  logic [CW-1:0] drop_cnt;
`endif

  int tests_run;
  int tests_failed;

  logic [DW-1:0] sb[$];
  logic          m_ovf;
  logic [CW-1:0] m_cnt;

  dff_pulse_capture dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .d       (d),
    .ready   (ready),
    .ovf_clr (ovf_clr),
    .valid   (valid),
    .q       (q),
    .full    (full),
    .ovf     (ovf)
`ifdef DFF_CAPTURE_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected head word: oldest scoreboard entry, zero when empty.
  function automatic logic [DW-1:0] exp_q();
    if (sb.size() == 0) return '0;
    return sb[0];
  endfunction

  // Advance the model with the currently driven inputs, then one clock.
  task automatic tick();
    bit m_full, m_valid, m_pop, m_push, m_drop;
    logic [DW-1:0] tmp;
    m_full  = (sb.size() == 2);
    m_valid = (sb.size() != 0);
    m_pop   = m_valid && ready;
    m_push  = en && (!m_full || m_pop);
    m_drop  = en && m_full && !m_pop;
    if (m_pop) tmp = sb.pop_front();
    if (m_push) sb.push_back(d);
    if (m_drop) begin
      m_ovf = 1'b1;
      m_cnt = ovf_clr ? 8'd1 : ((m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1);
    end else if (ovf_clr) begin
      m_ovf = 1'b0;
      m_cnt = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; d = '0; ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b exp 0", valid); end
    tests_run++; if (q !== 16'h0) begin tests_failed++; $display("FAIL reset_q got %h exp 0000", q); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %0b exp 0", full); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
`ifdef DFF_CAPTURE_DROP_CNT_EN
    tests_run++; if (drop_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
`endif
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ready = 1'b1; en = 1'b1; d = 16'hA5A5;
    tick();
    en = 1'b0; d = 16'hFFFF;
    tests_run++; if (valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid got %0b exp 1", valid); end
    tests_run++; if (q !== 16'hA5A5) begin tests_failed++; $display("FAIL single_q got %h exp a5a5", q); end
    tests_run++; if (q !== exp_q()) begin tests_failed++; $display("FAIL single_sb got %h exp %h", q, exp_q()); end
    tick();
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL single_drain_valid got %0b exp 0", valid); end
    tests_run++; if (q !== 16'h0) begin tests_failed++; $display("FAIL single_drain_q got %h exp 0000", q); end
    // en low with nonzero d must not load anything
    tick();
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL en_low_valid got %0b exp 0", valid); end
  endtask

  task automatic test_back_to_back();
    ready = 1'b0; en = 1'b1; d = 16'd1;
    tick();
    d = 16'd2;
    tick();
    en = 1'b0;
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL b2b_full got %0b exp 1", full); end
    tests_run++; if (q !== 16'd1) begin tests_failed++; $display("FAIL b2b_hold_q got %h exp 0001", q); end
    tick();
    tests_run++; if (q !== 16'd1) begin tests_failed++; $display("FAIL b2b_stall_q got %h exp 0001", q); end
    ready = 1'b1;
    tick();
    tests_run++; if (q !== 16'd2) begin tests_failed++; $display("FAIL b2b_second_q got %h exp 0002", q); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL b2b_one_full got %0b exp 0", full); end
    tests_run++; if (q !== exp_q()) begin tests_failed++; $display("FAIL b2b_sb got %h exp %h", q, exp_q()); end
    tick();
    tests_run++; if (valid !== 1'b0 || q !== 16'h0) begin tests_failed++; $display("FAIL b2b_empty got valid=%0b q=%h exp valid=0 q=0000", valid, q); end
  endtask

  task automatic test_drop();
    ready = 1'b0; en = 1'b1; d = 16'd1;
    tick();
    d = 16'd2;
    tick();
    d = 16'd3;
    tick();
    en = 1'b0;
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL drop_full got %0b exp 1", full); end
    tests_run++; if (q !== 16'd1) begin tests_failed++; $display("FAIL drop_q got %h exp 0001", q); end
    tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL drop_ovf got %0b exp 1", ovf); end
`ifdef DFF_CAPTURE_DROP_CNT_EN
    tests_run++; if (drop_cnt !== 8'd1) begin tests_failed++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt); end
`endif
  endtask

  task automatic test_full_pop_push();
    // buffer holds 1,2 with ovf set: clear ovf alone first
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL clr_alone_ovf got %0b exp 0", ovf); end
`ifdef DFF_CAPTURE_DROP_CNT_EN
    tests_run++; if (drop_cnt !== 8'd0) begin tests_failed++; $display("FAIL clr_alone_cnt got %0d exp 0", drop_cnt); end
`endif
    ready = 1'b1; en = 1'b1; d = 16'd3;
    tick();
    en = 1'b0;
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL popush_ovf got %0b exp 0", ovf); end
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL popush_full got %0b exp 1", full); end
    tests_run++; if (q !== 16'd2) begin tests_failed++; $display("FAIL popush_q0 got %h exp 0002", q); end
    tick();
    tests_run++; if (q !== 16'd3) begin tests_failed++; $display("FAIL popush_q1 got %h exp 0003", q); end
    tick();
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL popush_empty got %0b exp 0", valid); end
  endtask

  task automatic test_ovf_clr_race();
    ready = 1'b0; en = 1'b1; d = 16'h0011;
    tick();
    d = 16'h0022;
    tick();
    d = 16'h0033;
    tick();
    tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL race_pre_ovf got %0b exp 1", ovf); end
    d = 16'h0044; ovf_clr = 1'b1;
    tick();
    en = 1'b0;
    tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL race_ovf got %0b exp 1", ovf); end
`ifdef DFF_CAPTURE_DROP_CNT_EN
    tests_run++; if (drop_cnt !== 8'd1) begin tests_failed++; $display("FAIL race_cnt got %0d exp 1", drop_cnt); end
`endif
    tick();
    ovf_clr = 1'b0;
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL race_clr_ovf got %0b exp 0", ovf); end
    tests_run++; if (q !== 16'h0011) begin tests_failed++; $display("FAIL race_q got %h exp 0011", q); end
`ifdef DFF_CAPTURE_DROP_CNT_EN
    en = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    en = 1'b0;
    tests_run++; if (drop_cnt !== 8'hFF) begin tests_failed++; $display("FAIL cnt_sat got %0d exp 255", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    // buffer is full from the previous scenario
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_full got %0b exp 1", full); end
    #3 rstn = 1'b0;
    #1;
    model_reset();
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid got %0b exp 0", valid); end
    tests_run++; if (q !== 16'h0) begin tests_failed++; $display("FAIL mid_q got %h exp 0000", q); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL mid_full got %0b exp 0", full); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL mid_ovf got %0b exp 0", ovf); end
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    ovf_clr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      en      = ($urandom_range(0, 99) < 60);
      ready   = ($urandom_range(0, 99) < 50);
      ovf_clr = ($urandom_range(0, 99) < 10);
      d       = DW'($urandom);
      tick();
      tests_run++; if (valid !== (sb.size() != 0)) begin tests_failed++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", i, valid, sb.size() != 0); end
      tests_run++; if (q !== exp_q()) begin tests_failed++; $display("FAIL rnd_q cyc %0d got %h exp %h", i, q, exp_q()); end
      tests_run++; if (full !== (sb.size() == 2)) begin tests_failed++; $display("FAIL rnd_full cyc %0d got %0b exp %0b", i, full, sb.size() == 2); end
      tests_run++; if (ovf !== m_ovf) begin tests_failed++; $display("FAIL rnd_ovf cyc %0d got %0b exp %0b", i, ovf, m_ovf); end
`ifdef DFF_CAPTURE_DROP_CNT_EN
      tests_run++; if (drop_cnt !== m_cnt) begin tests_failed++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", i, drop_cnt, m_cnt); end
`endif
    end
    en = 1'b0; ovf_clr = 1'b0; ready = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_full_pop_push();
    test_ovf_clr_race();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
